count_seq_checker: RTL

//   Receive-side monitor for the upcounter's q bus. Samples a free-running count

---
 rtl/count_seq_checker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_checker
// Description : Receive-side monitor for an upcounter's q bus. Every enabled
//               sample is compared against the previous sample plus one
//               (modulo 2^WIDTH). Lock is declared after LOCK_CNT consecutive
//               correct steps. Mismatch and wrap are single-cycle pulses, and
//               err_cnt is a saturating count of mismatches.
//               Optional macro CNT_CHK_HALT_ON_ERR_EN: the first mismatch
//               parks the checker in HALT until rst.
// Revision    : 1.0 - initial release
// ============================================================================
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] exp_q
);

    // Wide enough to hold the value LOCK_CNT
    localparam int RUN_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

`ifdef CNT_CHK_HALT_ON_ERR_EN
    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        HALT   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;
`endif

    state_t           state;
    logic [RUN_W-1:0] run;
    logic             hit;
    logic [RUN_W-1:0] run_inc;
    logic [ERR_W-1:0] err_inc;

    // Compare the current sample and precompute the counter increments
    always_comb begin
        hit     = (q_in == exp_q);
        run_inc = run + 1'b1;
        err_inc = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + 1'b1;
    end

    // Checker state machine; every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACQ;
            locked   <= 1'b0;
            mismatch <= 1'b0;
            wrap     <= 1'b0;
            err_cnt  <= '0;
            exp_q    <= '0;
            run      <= '0;
        end else begin
            // Pulses last one cycle unless re-asserted below
            mismatch <= 1'b0;
            wrap     <= 1'b0;
            if (en) begin
                case (state)
                    ACQ: begin
                        exp_q <= q_in + 1'b1;
                        run   <= '0;
                        state <= TRACK;
                    end
                    TRACK: begin
                        exp_q <= q_in + 1'b1;
                        if (hit) begin
                            wrap <= (q_in == '0);
                            run  <= run_inc;
                            if (run_inc == RUN_W'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            mismatch <= 1'b1;
                            err_cnt  <= err_inc;
                            run      <= '0;
`ifdef CNT_CHK_HALT_ON_ERR_EN
                            state    <= HALT;
`endif
                        end
                    end
                    LOCKED: begin
                        exp_q <= q_in + 1'b1;
                        if (hit) begin
                            wrap <= (q_in == '0);
                        end else begin
                            mismatch <= 1'b1;
                            err_cnt  <= err_inc;
                            locked   <= 1'b0;
                            run      <= '0;
`ifdef CNT_CHK_HALT_ON_ERR_EN
                            state    <= HALT;
`else
                            state    <= TRACK;
`endif
                        end
                    end
                    // HALT (when built in): q_in ignored, everything frozen
                    default: begin
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
